// File: rtl/mem_responder_if.sv
// Request, write-data and read-response bundle between the arbiter
// (master) and the main-memory responder (slave).
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 26
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 5
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif

interface mem_responder_if;
  logic                          mem_req_valid;
  logic                          mem_req_ready;
  logic                          mem_req_rw;
  logic [`MEM_ADDR_BITS-1:0]     mem_req_addr;
  logic [`MEM_TAG_BITS-1:0]      mem_req_tag;
  logic                          mem_req_data_valid;
  logic                          mem_req_data_ready;
  logic [`MEM_DATA_BITS-1:0]     mem_req_data_bits;
  logic [`MEM_DATA_BITS/8-1:0]   mem_req_data_mask;
  logic [1:0]                    mem_req_data_offset;
  logic                          mem_resp_valid;
  logic [`MEM_DATA_BITS-1:0]     mem_resp_data;
  logic [`MEM_TAG_BITS-1:0]      mem_resp_tag;

  modport master (
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
    output mem_req_data_valid, mem_req_data_bits,
    output mem_req_data_mask, mem_req_data_offset,
    input  mem_req_ready, mem_req_data_ready,
    input  mem_resp_valid, mem_resp_data, mem_resp_tag
  );

  modport slave (
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
    input  mem_req_data_valid, mem_req_data_bits,
    input  mem_req_data_mask, mem_req_data_offset,
    output mem_req_ready, mem_req_data_ready,
    output mem_resp_valid, mem_resp_data, mem_resp_tag
  );
endinterface

// File: rtl/mem_responder.sv
// Behavioural main memory: in-order tagged line requests, 4-beat masked
// writes and 4-beat read bursts after a fixed latency.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 26
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 5
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif

module mem_responder #(
  parameter int LINES_LOG2   = 12,
  parameter int READ_LATENCY = 4,
  parameter int QDEPTH       = 4
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus
);
  localparam int DW = `MEM_DATA_BITS;
  localparam int MB = DW / 8;
  localparam int TW = `MEM_TAG_BITS;
  localparam int AB = `MEM_ADDR_BITS;
  localparam int QA = $clog2(QDEPTH);
  localparam int LW = $clog2(READ_LATENCY + 1);
  localparam int MI = LINES_LOG2 + 2;
  localparam logic [LW-1:0] LAT_LOAD =
    LW'(READ_LATENCY > 2 ? READ_LATENCY - 3 : 0);

  typedef enum logic [1:0] {
    S_IDLE, S_WDATA, S_RWAIT, S_RESP
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [1:0]            r_beat, w_beat_nxt;
  logic [LW-1:0]         r_lat, w_lat_nxt;
  logic [QA:0]           r_wp, r_rp, w_wp_nxt, w_rp_nxt;
  logic                  r_ready;
  logic                  r_q_rw  [QDEPTH];
  logic [LINES_LOG2-1:0] r_q_idx [QDEPTH];
  logic [TW-1:0]         r_q_tag [QDEPTH];
  logic [DW-1:0]         r_mem   [2**MI];
  logic [DW-1:0]         r_resp_data;
  logic [TW-1:0]         r_resp_tag;
  logic                  w_push, w_pop, w_empty;
  logic                  w_full_nxt, w_wacc;
  logic                  w_head_rw;
  logic [LINES_LOG2-1:0] w_head_idx;
  logic [TW-1:0]         w_head_tag;
  logic [MI-1:0]         w_widx;
  logic                  w_unused;

  // upper address bits alias onto the same line
  assign w_unused = ^bus.mem_req_addr[AB-1:LINES_LOG2];

  assign w_push   = bus.mem_req_valid & r_ready;
  assign w_empty  = (r_wp == r_rp);
  assign w_wp_nxt = r_wp + (QA+1)'(w_push);
  assign w_rp_nxt = r_rp + (QA+1)'(w_pop);
  assign w_full_nxt =
    (w_wp_nxt[QA] != w_rp_nxt[QA]) &&
    (w_wp_nxt[QA-1:0] == w_rp_nxt[QA-1:0]);

  assign w_head_rw  = r_q_rw[r_rp[QA-1:0]];
  assign w_head_idx = r_q_idx[r_rp[QA-1:0]];
  assign w_head_tag = r_q_tag[r_rp[QA-1:0]];

  assign w_wacc = (r_state == S_WDATA) & bus.mem_req_data_valid;
  assign w_widx = {w_head_idx, bus.mem_req_data_offset};

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_rw[r_wp[QA-1:0]]  <= bus.mem_req_rw;
      r_q_idx[r_wp[QA-1:0]] <= bus.mem_req_addr[LINES_LOG2-1:0];
      r_q_tag[r_wp[QA-1:0]] <= bus.mem_req_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wacc) begin
      for (int b = 0; b < MB; b++) begin
        if (bus.mem_req_data_mask[b])
          r_mem[w_widx][b*8 +: 8] <= bus.mem_req_data_bits[b*8 +: 8];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_lat_nxt   = r_lat;
    w_pop       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_beat_nxt = 2'd0;
          if (w_head_rw) begin
            w_state_nxt = S_WDATA;
          end else if (READ_LATENCY <= 2) begin
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_RWAIT;
            w_lat_nxt   = LAT_LOAD;
          end
        end
      end
      S_WDATA: begin
        if (w_wacc) begin
          w_beat_nxt = r_beat + 2'd1;
          if (r_beat == 2'd3) begin
            w_pop       = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_RWAIT: begin
        if (r_lat == '0) w_state_nxt = S_RESP;
        else             w_lat_nxt   = r_lat - 1'b1;
      end
      S_RESP: begin
        w_beat_nxt = r_beat + 2'd1;
        if (r_beat == 2'd3) begin
          w_pop       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_beat      <= 2'd0;
      r_lat       <= '0;
      r_wp        <= '0;
      r_rp        <= '0;
      r_ready     <= 1'b0;
      r_resp_data <= '0;
      r_resp_tag  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      r_lat   <= w_lat_nxt;
      r_wp    <= w_wp_nxt;
      r_rp    <= w_rp_nxt;
      r_ready <= !w_full_nxt;
      // beat k is fetched on the edge that enters beat k
      if (w_state_nxt == S_RESP) begin
        r_resp_data <= r_mem[{w_head_idx, w_beat_nxt}];
        r_resp_tag  <= w_head_tag;
      end
    end
  end

  assign bus.mem_req_ready      = r_ready;
  assign bus.mem_req_data_ready = (r_state == S_WDATA);
  assign bus.mem_resp_valid     = (r_state == S_RESP);
  assign bus.mem_resp_data      = r_resp_data;
  assign bus.mem_resp_tag       = r_resp_tag;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: vector table of line writes/reads with a
// response scoreboard, plus queue-full, ignored-beat and reset sequences.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 26
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 5
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif

module tb_mem_responder;
  localparam int DW = `MEM_DATA_BITS;
  localparam int MW = DW / 8;
  localparam int AW = `MEM_ADDR_BITS;
  localparam int TW = `MEM_TAG_BITS;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_responder_if m ();

  mem_responder dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (m)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    bit            first;
    int            acc;
  } sb_t;

  typedef struct {
    bit                   rw;
    logic [AW-1:0]        addr;
    logic [TW-1:0]        tag;
    logic [3:0][1:0]      off;
    logic [3:0][MW-1:0]   mk;
    logic [3:0][DW-1:0]   d;
  } vec_t;

  sb_t sb[$];
  int  n_chk = 0;
  int  n_pass = 0;
  int  n_beats = 0;

  task automatic chk(input string nm,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    $display("FAIL %s: got timeout expected event", nm);
  endtask

  always @(negedge clk) begin
    if (rst_n && m.mem_resp_valid) begin
      n_beats++;
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL extra_beat: got tag %0d expected no beat",
                 m.mem_resp_tag);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("resp_data", m.mem_resp_data, e.data);
        chk("resp_tag", DW'(m.mem_resp_tag), DW'(e.tag));
        if (e.first) chk("latency", DW'(cyc - e.acc), DW'(4));
      end
    end
  end

  function automatic logic [DW-1:0] fill(input logic [7:0] b);
    return {MW{b}};
  endfunction

  function automatic vec_t mk_v(input bit rw, input logic [AW-1:0] a,
                                input logic [TW-1:0] t,
                                input logic [DW-1:0] d0, d1, d2, d3);
    vec_t x;
    x.rw   = rw;
    x.addr = a;
    x.tag  = t;
    x.d    = {d3, d2, d1, d0};
    x.mk   = {4{{MW{1'b1}}}};
    x.off  = {2'd3, 2'd2, 2'd1, 2'd0};
    return x;
  endfunction

  task automatic req(input bit rw, input logic [AW-1:0] a,
                     input logic [TW-1:0] t, output int acc);
    int n = 0;
    m.mem_req_valid = 1'b1;
    m.mem_req_rw    = rw;
    m.mem_req_addr  = a;
    m.mem_req_tag   = t;
    while (!m.mem_req_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) fail_now("req_ready");
    acc = cyc;
    @(posedge clk); #1;
    m.mem_req_valid = 1'b0;
  endtask

  task automatic wbeat(input logic [1:0] off, input logic [DW-1:0] d,
                       input logic [MW-1:0] mk);
    int n = 0;
    m.mem_req_data_valid  = 1'b1;
    m.mem_req_data_offset = off;
    m.mem_req_data_bits   = d;
    m.mem_req_data_mask   = mk;
    while (!m.mem_req_data_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) fail_now("data_ready");
    @(posedge clk); #1;
    m.mem_req_data_valid = 1'b0;
  endtask

  task automatic expect_line(input logic [TW-1:0] t, input bit first,
                             input int acc, input logic [3:0][DW-1:0] d);
    for (int k = 0; k < 4; k++)
      sb.push_back('{t, d[k], first && (k == 0), acc});
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (sb.size() != 0) begin
      fail_now("drain");
      sb.delete();
    end
  endtask

  task automatic wait_resp();
    int n = 0;
    while (!m.mem_resp_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) fail_now("resp_valid");
  endtask

  vec_t v[11];
  logic [3:0][DW-1:0] l10, l20, l30, l40;
  logic [DW-1:0] lo32;
  int acc, base;

  initial begin
    m.mem_req_valid       = 1'b0;
    m.mem_req_rw          = 1'b0;
    m.mem_req_addr        = '0;
    m.mem_req_tag         = '0;
    m.mem_req_data_valid  = 1'b0;
    m.mem_req_data_bits   = '0;
    m.mem_req_data_mask   = '0;
    m.mem_req_data_offset = '0;

    lo32 = '0;
    lo32[31:0] = 32'hFFFF_FFFF;
    l20 = {DW'(8'h44), DW'(8'h33), DW'(8'h22), DW'(8'h11)};
    l30 = {DW'(0), DW'(0), lo32, DW'(0)};
    l40 = {fill(8'hB3), fill(8'hB2), fill(8'hB1), fill(8'hB0)};
    l10 = {fill(8'hA3), fill(8'hC3), fill(8'hC2), fill(8'hC1)};

    v[0]  = mk_v(1, 26'h10, 0, fill(8'hA0), fill(8'hA1),
                 fill(8'hA2), fill(8'hA3));
    v[1]  = mk_v(0, 26'h10, 3, fill(8'hA0), fill(8'hA1),
                 fill(8'hA2), fill(8'hA3));
    v[2]  = mk_v(1, 26'h20, 1, l20[0], l20[1], l20[2], l20[3]);
    v[3]  = mk_v(0, 26'h20, 2, l20[0], l20[1], l20[2], l20[3]);
    v[4]  = mk_v(1, 26'h30, 4, '0, '0, '0, '0);
    v[5]  = mk_v(1, 26'h30, 5, '1, '1, '1, '1);
    v[5].mk = {MW'(0), MW'(0), MW'(16'h000F), MW'(0)};
    v[6]  = mk_v(0, 26'h30, 6, l30[0], l30[1], l30[2], l30[3]);
    v[7]  = mk_v(1, 26'h1040, 7, l40[0], l40[1], l40[2], l40[3]);
    v[8]  = mk_v(0, 26'h40, 8, l40[0], l40[1], l40[2], l40[3]);
    v[9]  = mk_v(1, 26'h10, 9, fill(8'hC0), fill(8'hC1),
                 fill(8'hC2), fill(8'hC3));
    v[9].off = {2'd2, 2'd1, 2'd0, 2'd0};
    v[10] = mk_v(0, 26'h10, 10, l10[0], l10[1], l10[2], l10[3]);

    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", DW'(m.mem_req_ready), DW'(0));
    chk("rst_data_ready", DW'(m.mem_req_data_ready), DW'(0));
    chk("rst_resp_valid", DW'(m.mem_resp_valid), DW'(0));
    chk("rst_resp_data", m.mem_resp_data, DW'(0));
    chk("rst_resp_tag", DW'(m.mem_resp_tag), DW'(0));
    repeat (3) @(posedge clk);
    chk("rst_ready_held", DW'(m.mem_req_ready), DW'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", DW'(m.mem_req_ready), DW'(1));

    for (int i = 0; i < 11; i++) begin
      if (v[i].rw) begin
        req(1'b1, v[i].addr, v[i].tag, acc);
        for (int k = 0; k < 4; k++)
          wbeat(v[i].off[k], v[i].d[k], v[i].mk[k]);
      end else begin
        req(1'b0, v[i].addr, v[i].tag, acc);
        expect_line(v[i].tag, 1'b1, acc, v[i].d);
        drain();
      end
    end

    base = n_beats;
    req(1'b0, 26'h20, 0, acc);
    expect_line(0, 1'b1, acc, l20);
    req(1'b0, 26'h10, 1, acc);
    expect_line(1, 1'b0, acc, l10);
    req(1'b0, 26'h30, 2, acc);
    expect_line(2, 1'b0, acc, l30);
    req(1'b0, 26'h40, 3, acc);
    expect_line(3, 1'b0, acc, l40);
    chk("ready_full", DW'(m.mem_req_ready), DW'(0));
    begin
      int n = 0;
      while (!m.mem_req_ready && n < 100) begin
        @(posedge clk); #1; n++;
      end
    end
    chk("ready_rise", DW'(m.mem_req_ready), DW'(1));
    chk("beats_at_ready_rise", DW'(n_beats - base), DW'(4));
    drain();
    chk("full_total_beats", DW'(n_beats - base), DW'(16));

    req(1'b0, 26'h20, 12, acc);
    expect_line(12, 1'b1, acc, l20);
    wait_resp();
    m.mem_req_data_valid  = 1'b1;
    m.mem_req_data_offset = 2'd0;
    m.mem_req_data_bits   = '1;
    m.mem_req_data_mask   = '1;
    #1;
    chk("data_ready_in_resp", DW'(m.mem_req_data_ready), DW'(0));
    @(posedge clk); #1;
    chk("data_ready_in_resp2", DW'(m.mem_req_data_ready), DW'(0));
    @(posedge clk); #1;
    m.mem_req_data_valid = 1'b0;
    drain();
    req(1'b0, 26'h20, 13, acc);
    expect_line(13, 1'b1, acc, l20);
    drain();

    base = n_beats;
    req(1'b0, 26'h20, 14, acc);
    expect_line(14, 1'b1, acc, l20);
    wait_resp();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", DW'(m.mem_resp_valid), DW'(0));
    chk("mid_rst_data", m.mem_resp_data, DW'(0));
    chk("mid_rst_tag", DW'(m.mem_resp_tag), DW'(0));
    chk("mid_rst_ready", DW'(m.mem_req_ready), DW'(0));
    chk("mid_rst_dready", DW'(m.mem_req_data_ready), DW'(0));
    chk("beats_before_rst", DW'(n_beats - base), DW'(2));
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_mid_rst", DW'(m.mem_req_ready), DW'(1));
    repeat (10) @(posedge clk);
    #1;
    chk("no_beats_after_rst", DW'(n_beats - base), DW'(2));
    req(1'b0, 26'h20, 15, acc);
    expect_line(15, 1'b1, acc, l20);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
